// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host-side physical layer.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RX,
    TX_INH,
    TX_REL,
    TX_BITS,
    TX_ACK
  } state_t;

  localparam int FRAME_BITS = 11;

  localparam logic [7:0] RESET   = 8'hFF;
  localparam logic [7:0] ACK     = 8'hFA;
  localparam logic [7:0] RESEND  = 8'hFE;
  localparam logic [7:0] SET_LED = 8'hED;

  // Rounds up so that a programmed time is never shortened.
  function automatic int us_to_cycles(input longint clk_hz, input longint us);
    return int'((clk_hz * us + 64'sd999_999) / 64'sd1_000_000);
  endfunction

endpackage

// File: rtl/ps2_phy_if.sv
// Byte-level handshake between the keyboard register block (master) and ps2_phy (slave).
interface ps2_phy_if;
  logic       istrobe;
  logic [7:0] ibyte;
  logic       oreq;
  logic [7:0] obyte;
  logic       oack;
  logic       timeout;

  modport master (input istrobe, ibyte, oack, timeout, output oreq, obyte);
  modport slave  (output istrobe, ibyte, oack, timeout, input oreq, obyte);
endinterface

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser, stability filter and falling-edge pulse for one PS/2 line.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic line,
  output logic filt,
  output logic fall
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // NOTE: sync and filter state reset to 1 because an idle open-drain line is pulled high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= 2'b11;
      filt <= 1'b1;
      cnt  <= '0;
      fall <= 1'b0;
    end else begin
      sync <= {sync[0], line};
      fall <= 1'b0;
      if (sync[1] == filt) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        filt <= sync[1];
        fall <= filt;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_phy.sv
// PS/2 host PHY: deframes device frames and serialises host commands on open-drain lines.
// Define PS2_PHY_PARITY_CHK_EN to discard received frames with bad parity or stop bit.
module ps2_phy
  import ps2_pkg::*;
#(
  parameter int CLK_HZ     = 25_000_000,
  parameter int INHIBIT_US = 120,
  parameter int TIMEOUT_US = 2000,
  parameter int FILTER_LEN = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  inout  wire        ps2clk,
  inout  wire        ps2dat,
  ps2_phy_if.slave   bus
);

  localparam int INH_CYC = us_to_cycles(CLK_HZ, INHIBIT_US);
  localparam int TO_CYC  = us_to_cycles(CLK_HZ, TIMEOUT_US);
  localparam int CW      = $clog2(TO_CYC) + 1;

  state_t        state, state_nxt;
  logic          clk_f, clk_fall, dat_f, dat_fall_unused;
  logic [3:0]    bit_cnt;
  logic [8:0]    rx_sh;
  logic [7:0]    tx_byte, ibyte_q;
  logic [9:0]    tx_frame;
  logic [CW-1:0] inh_cnt, wd_cnt;
  logic          istrobe_q, oack_q, timeout_q;
  logic          wd_active, wd_expired, inh_done, start_det, rx_ok;
  logic          clk_low, dat_low;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk(clk), .rst_n(rst_n), .line(ps2clk), .filt(clk_f), .fall(clk_fall)
  );
  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filt (
    .clk(clk), .rst_n(rst_n), .line(ps2dat), .filt(dat_f), .fall(dat_fall_unused)
  );

  assign start_det  = (state == IDLE) && clk_fall && !dat_f;
  assign wd_active  = !(state inside {IDLE, TX_INH});
  assign wd_expired = wd_active && (wd_cnt == CW'(TO_CYC - 1));
  assign inh_done   = (inh_cnt == CW'(INH_CYC - 1));
  assign tx_frame   = {1'b1, ~^tx_byte, tx_byte};

`ifdef PS2_PHY_PARITY_CHK_EN
  // rx_sh holds data plus parity; their XOR is 1 exactly when parity is odd.
  assign rx_ok = (^rx_sh) && dat_f;
`else
  assign rx_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.oreq) begin
      state_nxt = TX_INH;
    end else if (wd_expired) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (start_det) state_nxt = RX;
        RX:      if (clk_fall && bit_cnt == 4'd9) state_nxt = IDLE;
        TX_INH:  if (inh_done) state_nxt = TX_REL;
        TX_REL:  if (clk_fall) state_nxt = TX_BITS;
        TX_BITS: if (clk_fall && bit_cnt == 4'd8) state_nxt = TX_ACK;
        TX_ACK:  if (clk_fall) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // NOTE: both drives get a default first so no path through the case infers a latch.
  always_comb begin
    clk_low = 1'b0;
    dat_low = 1'b0;
    case (state)
      TX_INH: begin
        clk_low = 1'b1;
        dat_low = inh_done;
      end
      TX_REL:  dat_low = 1'b1;
      TX_BITS: dat_low = !tx_frame[bit_cnt];
      default: ;
    endcase
  end

  // Drives follow state combinationally, so an asserted reset releases the lines at once.
  assign ps2clk = clk_low ? 1'b0 : 1'bz;
  assign ps2dat = dat_low ? 1'b0 : 1'bz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt   <= '0;
      rx_sh     <= '0;
      tx_byte   <= '0;
      inh_cnt   <= '0;
      ibyte_q   <= '0;
      istrobe_q <= 1'b0;
      oack_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      istrobe_q <= 1'b0;
      oack_q    <= 1'b0;
      if (bus.oreq) begin
        tx_byte   <= bus.obyte;
        timeout_q <= 1'b0;
        inh_cnt   <= '0;
      end else if (wd_expired) begin
        timeout_q <= 1'b1;
      end else begin
        case (state)
          IDLE: if (start_det) begin
            bit_cnt   <= '0;
            timeout_q <= 1'b0;
          end
          RX: if (clk_fall) begin
            if (bit_cnt == 4'd9) begin
              if (rx_ok) begin
                ibyte_q   <= rx_sh[7:0];
                istrobe_q <= 1'b1;
              end
            end else begin
              rx_sh   <= {dat_f, rx_sh[8:1]};
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          TX_INH:  inh_cnt <= inh_cnt + 1'b1;
          TX_REL:  if (clk_fall) bit_cnt <= '0;
          TX_BITS: if (clk_fall) bit_cnt <= bit_cnt + 1'b1;
          TX_ACK: if (clk_fall) begin
            if (!dat_f) oack_q    <= 1'b1;
            else        timeout_q <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // Watchdog restarts on every clock edge and whenever the engine is not waiting on the device.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              wd_cnt <= '0;
    else if (!wd_active || clk_fall || bus.oreq) wd_cnt <= '0;
    else                                     wd_cnt <= wd_cnt + 1'b1;
  end

  assign bus.istrobe = istrobe_q;
  assign bus.ibyte   = ibyte_q;
  assign bus.oack    = oack_q;
  assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_ps2_phy.sv
// Directed bench for ps2_phy: a PS/2 device model drives the lines, a frame-level model predicts bytes and acks.
module tb_ps2_phy;
  import ps2_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wire ps2clk, ps2dat;
  pullup (ps2clk);
  pullup (ps2dat);
  logic dev_clk_low = 1'b0;
  logic dev_dat_low = 1'b0;
  assign ps2clk = dev_clk_low ? 1'b0 : 1'bz;
  assign ps2dat = dev_dat_low ? 1'b0 : 1'bz;

  ps2_phy_if bus ();

  ps2_phy #(
    .CLK_HZ(1_000_000), .INHIBIT_US(120), .TIMEOUT_US(2000), .FILTER_LEN(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ps2clk(ps2clk), .ps2dat(ps2dat), .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Frame-level model: bytes the device sends that must surface on ibyte, and acks still owed.
  logic [7:0] exp_rx[$];
  logic [7:0] model_ibyte = 8'h00;
  int         exp_ack  = 0;
  int         n_strobe = 0;

  function automatic bit frame_accepted(input logic [7:0] b, input bit par, input bit stop);
`ifdef PS2_PHY_PARITY_CHK_EN
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    ones += int'(par);
    return (ones % 2 == 1) && stop;
`else
    return 1'b1;
`endif
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.istrobe || bus.oack)
        check("strobe_oack_exclusive", 32'(bus.istrobe & bus.oack), 32'd0);
      if (bus.istrobe) begin
        n_strobe++;
        if (exp_rx.size() == 0) begin
          check("unexpected_istrobe", 32'(bus.istrobe), 32'd0);
        end else begin
          model_ibyte = exp_rx.pop_front();
          check("ibyte", 32'(bus.ibyte), 32'(model_ibyte));
        end
      end else if (bus.ibyte !== model_ibyte) begin
        check("ibyte_stable", 32'(bus.ibyte), 32'(model_ibyte));
      end
      if (bus.oack) begin
        if (exp_ack == 0) check("unexpected_oack", 32'(bus.oack), 32'd0);
        else exp_ack--;
      end
    end
  end

  task automatic dev_bit(input bit v);
    dev_dat_low = !v;
    repeat (20) @(posedge clk);
    dev_clk_low = 1'b1;
    repeat (40) @(posedge clk);
    dev_clk_low = 1'b0;
    repeat (20) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit par, input bit stop, input int nbits);
    logic [10:0] f;
    f = {stop, par, b, 1'b0};
    for (int i = 0; i < nbits; i++) dev_bit(f[i]);
    dev_dat_low = 1'b0;
  endtask

  task automatic rx_frame(input string name, input logic [7:0] b, input bit par, input bit stop);
    if (frame_accepted(b, par, stop)) exp_rx.push_back(b);
    send_frame(b, par, stop, FRAME_BITS);
    repeat (30) @(negedge clk);
    check({name, "_consumed"}, 32'(exp_rx.size()), 32'd0);
  endtask

  task automatic host_req(input logic [7:0] b);
    @(negedge clk);
    bus.oreq  = 1'b1;
    bus.obyte = b;
    @(negedge clk);
    bus.oreq  = 1'b0;
  endtask

  // Device side of a host-to-device transfer: observes inhibit, clocks 'pulses' bits, acks on pulse 11.
  task automatic dev_host_tx(input int pulses, output logic [9:0] bits, output int inh_len);
    int w;
    w = 0;
    bits = '0;
    inh_len = 0;
    while (ps2clk !== 1'b0 && w < 500) begin
      @(negedge clk);
      w++;
    end
    check("inhibit_seen", 32'(ps2clk), 32'd0);
    while (ps2clk === 1'b0 && inh_len < 1000) begin
      @(negedge clk);
      inh_len++;
    end
    check("start_bit_low", 32'(ps2dat), 32'd0);
    repeat (30) @(posedge clk);
    for (int k = 1; k <= pulses; k++) begin
      if (k == 11) dev_dat_low = 1'b1;
      repeat (20) @(posedge clk);
      dev_clk_low = 1'b1;
      repeat (40) @(posedge clk);
      dev_clk_low = 1'b0;
      @(negedge clk);
      if (k <= 10) bits[k-1] = ps2dat;
      if (k == 11) dev_dat_low = 1'b0;
      repeat (20) @(posedge clk);
    end
  endtask

  initial begin
    #600_000;
    $display("FAIL global_time_limit: simulation did not complete");
    $fatal(1, "time limit");
  end

  initial begin
    logic [9:0] bits;
    int         inh;
    int         w;

    bus.oreq  = 1'b0;
    bus.obyte = 8'h00;
    repeat (5) @(negedge clk);
    check("rst_istrobe", 32'(bus.istrobe), 32'd0);
    check("rst_ibyte",   32'(bus.ibyte),   32'h00);
    check("rst_oack",    32'(bus.oack),    32'd0);
    check("rst_timeout", 32'(bus.timeout), 32'd0);
    check("rst_ps2clk",  32'(ps2clk),      32'd1);
    check("rst_ps2dat",  32'(ps2dat),      32'd1);
    check("rst_state",   32'(dut.state),   32'(IDLE));
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    // Good frame 0x1C: three ones, so the odd-parity bit is 0.
    rx_frame("rx_1c", 8'h1C, 1'b0, 1'b1);
    check("rx_1c_ibyte_literal", 32'(bus.ibyte), 32'h1C);
    check("rx_1c_strobes", 32'(n_strobe), 32'd1);
    check("rx_1c_timeout", 32'(bus.timeout), 32'd0);

    rx_frame("rx_1c_badpar", 8'h1C, 1'b1, 1'b1);
`ifdef PS2_PHY_PARITY_CHK_EN
    check("badpar_strobes", 32'(n_strobe), 32'd1);
`else
    check("badpar_strobes", 32'(n_strobe), 32'd2);
`endif
    check("badpar_ibyte_literal", 32'(bus.ibyte), 32'h1C);

    // Host transmit of SET_LED: data LSB first then parity 1 and stop 1.
    exp_ack = 1;
    host_req(SET_LED);
    dev_host_tx(11, bits, inh);
    check("led_inhibit_ge_120", 32'(inh >= 120), 32'd1);
    check("led_bits_literal", 32'(bits), 32'h3ED);
    check("led_bits_model", 32'(bits), 32'({1'b1, ~^SET_LED, SET_LED}));
    repeat (30) @(negedge clk);
    check("led_oack_seen", 32'(exp_ack), 32'd0);
    check("led_timeout", 32'(bus.timeout), 32'd0);

    // Device stalls after four bits; watchdog fires about 2000 cycles after the last edge.
    send_frame(8'h33, 1'b1, 1'b1, 4);
    repeat (1800) @(negedge clk);
    check("stall_no_early_timeout", 32'(bus.timeout), 32'd0);
    check("stall_state_rx", 32'(dut.state), 32'(RX));
    w = 0;
    while (!bus.timeout && w < 400) begin
      @(negedge clk);
      w++;
    end
    check("stall_timeout_set", 32'(bus.timeout), 32'd1);
    @(negedge clk);
    check("stall_state_idle", 32'(dut.state), 32'(IDLE));
    check("stall_ps2clk_rel", 32'(ps2clk), 32'd1);
    check("stall_ps2dat_rel", 32'(ps2dat), 32'd1);
    repeat (50) @(negedge clk);
    rx_frame("rx_f0", 8'hF0, 1'b1, 1'b1);
    check("rx_f0_ibyte_literal", 32'(bus.ibyte), 32'hF0);
    check("rx_f0_timeout_clear", 32'(bus.timeout), 32'd0);

    // Host request during a receive of 0x5A: the receive is dropped, the transmit completes.
    w = n_strobe;
    send_frame(8'h5A, 1'b1, 1'b1, 5);
    exp_ack = 1;
    host_req(RESET);
    dev_host_tx(11, bits, inh);
    check("abort_inhibit_ge_120", 32'(inh >= 120), 32'd1);
    check("abort_bits_literal", 32'(bits), 32'h3FF);
    repeat (30) @(negedge clk);
    check("abort_oack_seen", 32'(exp_ack), 32'd0);
    check("abort_no_strobe", 32'(n_strobe), 32'(w));

    // Reset during TX_BITS while the host drives data bit 3 of 0xA5 (a 0).
    host_req(8'hA5);
    dev_host_tx(4, bits, inh);
    check("txbits_state", 32'(dut.state), 32'(TX_BITS));
    check("txbits_d3_low", 32'(ps2dat), 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    exp_rx.delete();
    model_ibyte = 8'h00;
    exp_ack = 0;
    #1;
    check("midrst_ps2clk", 32'(ps2clk), 32'd1);
    check("midrst_ps2dat", 32'(ps2dat), 32'd1);
    check("midrst_ibyte", 32'(bus.ibyte), 32'h00);
    check("midrst_istrobe", 32'(bus.istrobe), 32'd0);
    check("midrst_oack", 32'(bus.oack), 32'd0);
    check("midrst_timeout", 32'(bus.timeout), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    rx_frame("rx_29", 8'h29, 1'b0, 1'b1);
    check("rx_29_ibyte_literal", 32'(bus.ibyte), 32'h29);

    repeat (10) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_phy.md
# ps2_phy

PS/2 host-side physical-layer engine: drives and samples the open-drain PS/2 clock and data lines, deframes 11-bit device-to-host frames into bytes and serialises host-to-device command bytes. It sits directly beneath the keyboard register block of the SuperIO. Upward it presents a one-cycle byte strobe, a one-cycle transmit acknowledge and a timeout flag. Downward it connects to the board PS/2 pins.

## Interface
- CLK_HZ, 25_000_000 — system clock frequency; derives the cycle counts below.
- INHIBIT_US, 120 — host clock-inhibit time before a transmit, in µs.
- TIMEOUT_US, 2000 — maximum gap between PS/2 clock falling edges inside a frame, in µs.
- FILTER_LEN, 8 — cycles a synchronised line must be stable before its filtered value changes.

- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- ps2clk  inout  1  PS/2 clock; driven 0 or high-Z only.
- ps2dat  inout  1  PS/2 data; driven 0 or high-Z only.
- istrobe  out  1  one-cycle pulse: ibyte holds a valid received byte.
- ibyte  out  8  last received byte; stable until the next istrobe.
- oreq  in  1  one-cycle request to transmit obyte.
- obyte  in  8  byte to transmit; sampled in the cycle where oreq=1.
- oack  out  1  one-cycle pulse: the device acknowledged the transmitted byte.
- timeout  out  1  level; set when a frame aborts on the watchdog.

## Operation
- ps2clk and ps2dat each pass through a 2-flop synchroniser and then the FILTER_LEN stability filter. Falling-edge detection uses the filtered clock only.
- States: IDLE, RX, TX_INH, TX_REL, TX_BITS, TX_ACK.
- IDLE to RX: a filtered clock falling edge with data=0 (start bit). A falling edge with data=1 is ignored.
- RX: shifts 8 data bits, LSB first, then parity, then stop, each on a clock falling edge.
  - After the stop bit, if parity is odd and stop=1: update ibyte, pulse istrobe, go to IDLE.
  - Otherwise discard the frame, go to IDLE, no istrobe.
- oreq in any state latches obyte, clears timeout and goes to TX_INH. A receive in progress is aborted; the host has priority.
- TX_INH: drive ps2clk low for INHIBIT_US. In the last inhibit cycle, start driving ps2dat low (start bit). Then go to TX_REL.
- TX_REL: release ps2clk, keep ps2dat low, wait for the first falling edge, then go to TX_BITS.
- TX_BITS: on each falling edge, present the next bit on ps2dat in this order:
  - data0 through data7, LSB first;
  - odd parity of obyte;
  - stop (release ps2dat).
  - A 1 bit means release; a 0 bit means drive low.
- TX_ACK: on the next falling edge, sample ps2dat.
  - 0: pulse oack, go to IDLE.
  - 1: go to IDLE, no oack, set timeout.
- Watchdog, active in every state except IDLE and TX_INH:
  - a counter reloads on each filtered clock falling edge;
  - on reaching the TIMEOUT_US count it releases both lines, sets timeout and forces IDLE.
- timeout clears on the next start-bit detection or on oreq.
- Reset mid-frame: both lines released immediately and all state cleared.

## Timing
- Values during reset: ps2clk=Z, ps2dat=Z, istrobe=0, ibyte=8'h00, oack=0, timeout=0, state=IDLE.
- Line-to-edge latency: 2 (sync) + FILTER_LEN cycles.
- istrobe is asserted in the cycle after the stop-bit falling edge is detected.
- oack is asserted in the cycle after the ack falling edge is detected.
- istrobe and oack are never both high in the same cycle.
- oreq while already in a TX state restarts the transmission with the new obyte.
- Counters use ceil(CLK_HZ*us/1e6) cycles. Counter widths are $clog2 of the TIMEOUT_US count plus 1.

## Configuration
- PS2_PHY_PARITY_CHK_EN:
  - Defined: received frames with a parity error or stop=0 are discarded (no istrobe).
  - Undefined: parity and stop are ignored, and every completed 11-edge frame pulses istrobe.
- Transmit parity generation is always present.

## Structure
- Package ps2_pkg holds:
  - the state enum;
  - FRAME_BITS=11;
  - command constants RESET=8'hFF, ACK=8'hFA, RESEND=8'hFE, SET_LED=8'hED;
  - the us-to-cycles conversion function.
- Sub-module ps2_line_filter (synchroniser, stability filter, falling-edge pulse) is instantiated twice, once for clock and once for data.
- Open-drain drive is done with conditional high-Z assigns in ps2_phy; no separate pad module.

## Test plan
- Device sends 0x1C with odd parity 0 and stop 1 -> one istrobe, ibyte=0x1C, timeout=0.
- Device sends 0x1C with parity bit 1 -> macro defined: no istrobe; macro undefined: istrobe with ibyte=0x1C.
- oreq with obyte=0xED -> ps2clk low for ≥120 µs, then ps2dat low; model clocks out bits 1,0,1,1,0,1,1,1, parity 1; model drives ack 0 -> one oack.
- Device stops clocking after 4 bits of a frame -> after 2 ms, timeout=1, lines released, state IDLE; the next valid frame 0xF0 gives istrobe and clears timeout.
- oreq(0xFF) issued mid-receive of 0x5A -> no istrobe for 0x5A, inhibit starts, transmit of 0xFF completes with oack.
- rst_n asserted during TX_BITS -> both lines Z within the same cycle, all outputs at reset values; after release, a 0x29 receive works normally.
